// File: rtl/fault_sim_pkg.sv
// Shared definitions for the stuck-at fault sweep engine: FSM state
// encoding and the width helper for the packed first-pattern result bus.
package fault_sim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOLD = 2'd1,
        FSIM = 2'd2,
        FIN  = 2'd3
    } sweep_state_t;

    // Width of the packed first-detecting-pattern bus (one N_IN slice per fault).
    function automatic int first_pat_width(input int n_fault, input int n_in);
        return n_fault * n_in;
    endfunction

endpackage

// File: rtl/fault_golden_ram.sv
// Golden response store: one CUT response per exhaustive input pattern.
// Written during the fault-free pass, read combinationally during fault passes.
module fault_golden_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Capture the fault-free response of the pattern currently being sampled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/fault_sweep_engine.sv
// Exhaustive stuck-at fault simulation sequencer. A fault-free pass records
// golden responses for all 2^N_IN patterns, then one pass per fault (one-hot
// fault_en) compares the CUT against them and logs detection results.
module fault_sweep_engine
    import fault_sim_pkg::*;
#(
    parameter int N_IN           = 3,
    parameter int N_OUT          = 1,
    parameter int N_FAULT        = 5,
    parameter int SETTLE         = 1,
    parameter bit DROP_ON_DETECT = 1'b0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic [N_IN-1:0]                           pat,
    output logic [N_FAULT-1:0]                        fault_en,
    input  logic [N_OUT-1:0]                          cut_out,
    output logic                                      busy,
    output logic                                      done,
    output logic [N_FAULT-1:0]                        fault_detected,
    output logic [first_pat_width(N_FAULT, N_IN)-1:0] first_pat,
    output logic [$clog2(N_FAULT+1)-1:0]              det_count
);

    localparam int PC_W = N_IN + 1;
    localparam int FI_W = (N_FAULT > 1) ? $clog2(N_FAULT) : 1;
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DC_W = $clog2(N_FAULT + 1);
    localparam int FP_W = first_pat_width(N_FAULT, N_IN);

    sweep_state_t        state_reg;
    logic [PC_W-1:0]     pat_cnt_reg;
    logic [SC_W-1:0]     settle_reg;
    logic [FI_W-1:0]     fault_idx_reg;
    logic [N_FAULT-1:0]  fault_en_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [N_FAULT-1:0]  fault_detected_reg;
    logic [FP_W-1:0]     first_pat_reg;
    logic [DC_W-1:0]     det_count_reg;

    logic                sample_edge;
    logic [PC_W-1:0]     pat_inc;
    logic                pat_last;
    logic [N_OUT-1:0]    golden_rd;
    logic                mismatch;
    logic                new_det;
    logic                pass_end;
    logic                last_fault;
    logic                gold_we;

    // The extra counter bit flags the wrap past the final pattern.
    assign pat_inc     = pat_cnt_reg + PC_W'(1);
    assign pat_last    = pat_inc[N_IN];
    assign sample_edge = ((state_reg == GOLD) || (state_reg == FSIM)) &&
                         (settle_reg == SC_W'(SETTLE - 1));
    assign gold_we     = (state_reg == GOLD) && sample_edge;
    assign mismatch    = (cut_out != golden_rd);
    assign new_det     = (state_reg == FSIM) && sample_edge && mismatch &&
                         !fault_detected_reg[fault_idx_reg];
    assign pass_end    = pat_last || (DROP_ON_DETECT && mismatch);
    assign last_fault  = (fault_idx_reg == FI_W'(N_FAULT - 1));

    fault_golden_ram #(
        .ADDR_W (N_IN),
        .DATA_W (N_OUT)
    ) u_golden (
        .clk   (clk),
        .we    (gold_we),
        .addr  (pat_cnt_reg[N_IN-1:0]),
        .wdata (cut_out),
        .rdata (golden_rd)
    );

    // Sweep sequencer: settle timing, pattern/fault stepping and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            pat_cnt_reg        <= '0;
            settle_reg         <= '0;
            fault_idx_reg      <= '0;
            fault_en_reg       <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            fault_detected_reg <= '0;
            first_pat_reg      <= '0;
            det_count_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fault_detected_reg <= '0;
                        first_pat_reg      <= '0;
                        det_count_reg      <= '0;
                        pat_cnt_reg        <= '0;
                        settle_reg         <= '0;
                        fault_idx_reg      <= '0;
                        fault_en_reg       <= '0;
                        busy_reg           <= 1'b1;
                        state_reg          <= GOLD;
                    end
                end
                GOLD: begin
                    if (sample_edge) begin
                        settle_reg <= '0;
                        if (pat_last) begin
                            pat_cnt_reg   <= '0;
                            fault_idx_reg <= '0;
                            fault_en_reg  <= N_FAULT'(1);
                            state_reg     <= FSIM;
                        end else begin
                            pat_cnt_reg <= pat_inc;
                        end
                    end else begin
                        settle_reg <= settle_reg + SC_W'(1);
                    end
                end
                FSIM: begin
                    if (sample_edge) begin
                        settle_reg <= '0;
                        if (new_det) begin
                            fault_detected_reg[fault_idx_reg] <= 1'b1;
                            first_pat_reg[int'(fault_idx_reg) * N_IN +: N_IN] <=
                                pat_cnt_reg[N_IN-1:0];
                            det_count_reg <= det_count_reg + DC_W'(1);
                        end
                        if (pass_end) begin
                            pat_cnt_reg <= '0;
                            if (last_fault) begin
                                fault_en_reg <= '0;
                                busy_reg     <= 1'b0;
                                done_reg     <= 1'b1;
                                state_reg    <= FIN;
                            end else begin
                                fault_en_reg  <= fault_en_reg << 1;
                                fault_idx_reg <= fault_idx_reg + FI_W'(1);
                            end
                        end else begin
                            pat_cnt_reg <= pat_inc;
                        end
                    end else begin
                        settle_reg <= settle_reg + SC_W'(1);
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pat            = pat_cnt_reg[N_IN-1:0];
    assign fault_en       = fault_en_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign fault_detected = fault_detected_reg;
    assign first_pat      = first_pat_reg;
    assign det_count      = det_count_reg;

endmodule

// File: tb/tb_fault_sweep_engine.sv
// Directed bench for fault_sweep_engine. CUT: f=(a&b)|c with a=pat[2], b=pat[1],
// c=pat[0]; fault0 = a stuck-at-1, fault1 = c stuck-at-0, fault2 (where present)
// is redundant. Four engine instances cover the no-drop, drop, redundant-fault
// and SETTLE=3 registered-CUT configurations.
module tb_fault_sweep_engine;

    logic       clk;
    logic       rst_n;
    logic [3:0] start_v;
    logic [3:0] done_v;
    logic [3:0] busy_v;

    int total;
    int bad;

    // Instance A: no dropping, SETTLE=1
    logic [2:0] pat_a;
    logic [1:0] fen_a;
    logic       cut_a;
    logic [1:0] fd_a;
    logic [5:0] fp_a;
    logic [1:0] dc_a;
    // Instance B: fault dropping
    logic [2:0] pat_b;
    logic [1:0] fen_b;
    logic       cut_b;
    logic [1:0] fd_b;
    logic [5:0] fp_b;
    logic [1:0] dc_b;
    // Instance C: three faults, fault2 redundant
    logic [2:0] pat_c;
    logic [2:0] fen_c;
    logic       cut_c;
    logic [2:0] fd_c;
    logic [8:0] fp_c;
    logic [1:0] dc_c;
    // Instance D: SETTLE=3, registered CUT
    logic [2:0] pat_d;
    logic [1:0] fen_d;
    logic       cut_d;
    logic [1:0] fd_d;
    logic [5:0] fp_d;
    logic [1:0] dc_d;

    function automatic logic cut_f(input logic [2:0] p, input logic [2:0] fe);
        logic a, b, c;
        a = p[2] | fe[0];
        b = p[1];
        c = p[0] & ~fe[1];
        return (a & b) | c;
    endfunction

    assign cut_a = cut_f(pat_a, {1'b0, fen_a});
    assign cut_b = cut_f(pat_b, {1'b0, fen_b});
    assign cut_c = cut_f(pat_c, fen_c);

    always_ff @(posedge clk) begin
        cut_d <= cut_f(pat_d, {1'b0, fen_d});
    end

    fault_sweep_engine #(.N_IN(3), .N_OUT(1), .N_FAULT(2), .SETTLE(1), .DROP_ON_DETECT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .pat(pat_a), .fault_en(fen_a),
        .cut_out(cut_a), .busy(busy_v[0]), .done(done_v[0]), .fault_detected(fd_a),
        .first_pat(fp_a), .det_count(dc_a));

    fault_sweep_engine #(.N_IN(3), .N_OUT(1), .N_FAULT(2), .SETTLE(1), .DROP_ON_DETECT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pat(pat_b), .fault_en(fen_b),
        .cut_out(cut_b), .busy(busy_v[1]), .done(done_v[1]), .fault_detected(fd_b),
        .first_pat(fp_b), .det_count(dc_b));

    fault_sweep_engine #(.N_IN(3), .N_OUT(1), .N_FAULT(3), .SETTLE(1), .DROP_ON_DETECT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .pat(pat_c), .fault_en(fen_c),
        .cut_out(cut_c), .busy(busy_v[2]), .done(done_v[2]), .fault_detected(fd_c),
        .first_pat(fp_c), .det_count(dc_c));

    fault_sweep_engine #(.N_IN(3), .N_OUT(1), .N_FAULT(2), .SETTLE(3), .DROP_ON_DETECT(1'b0)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .pat(pat_d), .fault_en(fen_d),
        .cut_out(cut_d), .busy(busy_v[3]), .done(done_v[3]), .fault_detected(fd_d),
        .first_pat(fp_d), .det_count(dc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: one-cycle start; returns at the negedge after edge S.
    task automatic pulse_start(input int i);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    // Stimulus helper: counts edges after S until done (bounded).
    task automatic wait_done(input int i, input int limit, output int n);
        n = 0;
        while (!done_v[i] && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({pat_a, fen_a, busy_v[0], done_v[0]} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%0h exp=0", {pat_a, fen_a, busy_v[0], done_v[0]});
        end
        total++;
        if ({fd_a, fp_a, dc_a} !== 10'b0) begin
            bad++;
            $display("FAIL reset_results got=%0h exp=0", {fd_a, fp_a, dc_a});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy_v !== 4'b0 || done_v !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b done=%b exp=0000", busy_v, done_v);
        end
    endtask

    task automatic test_no_drop();
        int n;
        logic [2:0] exp_p;
        logic [1:0] exp_f;
        pulse_start(0);
        n = 0;
        while (!done_v[0] && n < 100) begin
            exp_p = 3'(n % 8);
            exp_f = (n < 8) ? 2'b00 : (n < 16) ? 2'b01 : 2'b10;
            total++;
            if (busy_v[0] !== 1'b1 || pat_a !== exp_p || fen_a !== exp_f) begin
                bad++;
                $display("FAIL seq_a n=%0d got busy=%b pat=%0d fen=%b exp busy=1 pat=%0d fen=%b",
                         n, busy_v[0], pat_a, fen_a, exp_p, exp_f);
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 24) begin
            bad++;
            $display("FAIL done_lat_a got=%0d exp=24", n);
        end
        total++;
        if (busy_v[0] !== 1'b0 || pat_a !== 3'd0 || fen_a !== 2'b00) begin
            bad++;
            $display("FAIL end_ctrl_a got busy=%b pat=%0d fen=%b exp 0", busy_v[0], pat_a, fen_a);
        end
        total++;
        if (fd_a !== 2'b11 || fp_a !== 6'b001_010 || dc_a !== 2'd2) begin
            bad++;
            $display("FAIL results_a got fd=%b fp=%b dc=%0d exp fd=11 fp=001010 dc=2", fd_a, fp_a, dc_a);
        end
        @(negedge clk);
        total++;
        if (done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_a got=%b exp=0", done_v[0]);
        end
        repeat (3) @(negedge clk);
        total++;
        if (fd_a !== 2'b11 || fp_a !== 6'b001_010 || dc_a !== 2'd2 || busy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL hold_a got fd=%b fp=%b dc=%0d busy=%b exp fd=11 fp=001010 dc=2 busy=0",
                     fd_a, fp_a, dc_a, busy_v[0]);
        end
    endtask

    task automatic test_drop();
        int n;
        pulse_start(1);
        wait_done(1, 100, n);
        total++;
        if (n !== 13) begin
            bad++;
            $display("FAIL done_lat_b got=%0d exp=13", n);
        end
        total++;
        if (fd_b !== 2'b11 || fp_b !== 6'b001_010 || dc_b !== 2'd2) begin
            bad++;
            $display("FAIL results_b got fd=%b fp=%b dc=%0d exp fd=11 fp=001010 dc=2", fd_b, fp_b, dc_b);
        end
    endtask

    task automatic test_redundant();
        int n;
        pulse_start(2);
        wait_done(2, 100, n);
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL done_lat_c got=%0d exp=32", n);
        end
        total++;
        if (fd_c !== 3'b011 || fp_c !== 9'b000_001_010 || dc_c !== 2'd2) begin
            bad++;
            $display("FAIL results_c got fd=%b fp=%b dc=%0d exp fd=011 fp=000001010 dc=2", fd_c, fp_c, dc_c);
        end
    endtask

    task automatic test_settle();
        int n;
        logic [2:0] exp_p;
        logic [1:0] exp_f;
        pulse_start(3);
        n = 0;
        while (!done_v[3] && n < 200) begin
            exp_p = 3'((n / 3) % 8);
            exp_f = (n < 24) ? 2'b00 : (n < 48) ? 2'b01 : 2'b10;
            total++;
            if (pat_d !== exp_p || fen_d !== exp_f) begin
                bad++;
                $display("FAIL seq_d n=%0d got pat=%0d fen=%b exp pat=%0d fen=%b",
                         n, pat_d, fen_d, exp_p, exp_f);
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 72) begin
            bad++;
            $display("FAIL done_lat_d got=%0d exp=72", n);
        end
        total++;
        if (fd_d !== 2'b11 || fp_d !== 6'b001_010 || dc_d !== 2'd2) begin
            bad++;
            $display("FAIL results_d got fd=%b fp=%b dc=%0d exp fd=11 fp=001010 dc=2", fd_d, fp_d, dc_d);
        end
    endtask

    task automatic test_control();
        int n;
        pulse_start(0);
        repeat (4) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        total++;
        if (pat_a !== 3'd5 || busy_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_start got pat=%0d busy=%b exp pat=5 busy=1", pat_a, busy_v[0]);
        end
        repeat (7) @(negedge clk);
        total++;
        if (fen_a !== 2'b01 || pat_a !== 3'd4 || fd_a !== 2'b01) begin
            bad++;
            $display("FAIL mid_fsim got fen=%b pat=%0d fd=%b exp fen=01 pat=4 fd=01", fen_a, pat_a, fd_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pat_a, fen_a, busy_v[0], done_v[0], fd_a, fp_a, dc_a} !== 17'b0) begin
            bad++;
            $display("FAIL async_reset got=%0h exp=0", {pat_a, fen_a, busy_v[0], done_v[0], fd_a, fp_a, dc_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        wait_done(0, 100, n);
        total++;
        if (n !== 24) begin
            bad++;
            $display("FAIL done_lat_restart got=%0d exp=24", n);
        end
        total++;
        if (fd_a !== 2'b11 || fp_a !== 6'b001_010 || dc_a !== 2'd2) begin
            bad++;
            $display("FAIL results_restart got fd=%b fp=%b dc=%0d exp fd=11 fp=001010 dc=2", fd_a, fp_a, dc_a);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_start(0);
        wait_done(0, 100, n);
        total++;
        if (n !== 24) begin
            bad++;
            $display("FAIL done_lat_b2b1 got=%0d exp=24", n);
        end
        @(negedge clk);
        total++;
        if (done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_b2b got=%b exp=0", done_v[0]);
        end
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        total++;
        if (busy_v[0] !== 1'b1 || fd_a !== 2'b00 || fp_a !== 6'b0 || dc_a !== 2'd0 || pat_a !== 3'd0) begin
            bad++;
            $display("FAIL b2b_clear got busy=%b fd=%b fp=%b dc=%0d pat=%0d exp busy=1 rest 0",
                     busy_v[0], fd_a, fp_a, dc_a, pat_a);
        end
        wait_done(0, 100, n);
        total++;
        if (n !== 24) begin
            bad++;
            $display("FAIL done_lat_b2b2 got=%0d exp=24", n);
        end
        total++;
        if (fd_a !== 2'b11 || fp_a !== 6'b001_010 || dc_a !== 2'd2) begin
            bad++;
            $display("FAIL results_b2b got fd=%b fp=%b dc=%0d exp fd=11 fp=001010 dc=2", fd_a, fp_a, dc_a);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start_v = 4'b0;
        test_reset();
        test_no_drop();
        test_drop();
        test_redundant();
        test_settle();
        test_control();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fault_sweep_engine.md
# fault_sweep_engine

- Synthesizable, parametrised stuck-at fault-simulation engine for an external combinational circuit-under-test (CUT).
- Runs a fault-free pass that applies all 2^N_IN patterns and stores the golden responses.
- Then runs one pass per injectable fault, with that fault's enable asserted, and records per fault whether it was detected and the first detecting pattern.
- Sits beside the CUT wrapper; the wrapper owns the stuck values, and this block drives only one-hot fault enables.

## Interface
- N_IN, 3: CUT primary-input width; exhaustive pattern space is 2^N_IN.
- N_OUT, 1: CUT output width.
- N_FAULT, 5: number of injectable faults.
- SETTLE, 1: cycles between driving a pattern and sampling the CUT output; must be at least 1.
- DROP_ON_DETECT, 0: when 1, a fault pass ends at the first detecting pattern (fault dropping).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- pat  out  N_IN  pattern driven to the CUT inputs (MSB = first input).
- fault_en  out  N_FAULT  one-hot fault injection select; all zero during the fault-free pass.
- cut_out  in  N_OUT  CUT response.
- busy  out  1  high from start acceptance until the sweep ends.
- done  out  1  one-cycle pulse at the end of the sweep.
- fault_detected  out  N_FAULT  bit k set if fault k was detected by any pattern.
- first_pat  out  N_FAULT*N_IN  slice k is the first detecting pattern for fault k; 0 if the fault is undetected.
- det_count  out  $clog2(N_FAULT+1)  number of detected faults.

## Operation
- **States:**
  - IDLE: waits for start.
  - GOLD: fault-free pass.
  - FSIM: fault passes.
  - FIN: single-cycle state, then back to IDLE.
- **Start acceptance:**
  - start in IDLE: clear all results, pat<=0, fault_en<=0, busy<=1, go to GOLD.
  - start in any other state is ignored.
- **GOLD:** at each sample edge, golden[pat] <= cut_out and pat increments.
- **GOLD to FSIM:** after the sample at pat = 2^N_IN-1, pat wraps to 0, fault_en <= one-hot bit 0, state becomes FSIM.
- **FSIM sample edge (fault k):** compare cut_out against golden[pat]. On a mismatch where fault_detected[k] is still 0:
  - set fault_detected[k];
  - capture first_pat[k] = pat;
  - increment det_count.
- **End of a fault pass:** the pass ends on the last pattern, or, if DROP_ON_DETECT=1, on the first mismatch edge. At that same edge:
  - pat <= 0 and fault_en shifts left by one;
  - after fault N_FAULT-1, go to FIN with fault_en <= 0, pat <= 0, busy <= 0, and done high for one cycle.
- **Results:** remain stable until the next accepted start.
- **Pattern counter:** N_IN+1 bits internally; pattern wrap is detected on the extra bit.
- **Reset values (rst_n low at any time, including mid-sweep):**
  - state IDLE;
  - pat, fault_en, busy, done, fault_detected, first_pat and det_count all 0;
  - golden contents are don't-care.

## Timing
- The start-accepting edge is S. The pattern driven at edge E is sampled at edge E+SETTLE.
- The sample edge drives the next pattern, so there are no idle cycles between patterns or between passes.
- Without fault dropping, the total number of samples is P = (N_FAULT+1)*2^N_IN.
  - The last sample occurs at edge S+SETTLE*P.
  - busy falls and done rises at that edge; done clears on the next edge.
- With DROP_ON_DETECT=1, P is the actual number of samples taken.
- Golden read is combinational on pat. The golden write and the compare of the same entry never occur in the same pass.

## Structure
- Package fault_sim_pkg holds:
  - the state encoding (IDLE, GOLD, FSIM, FIN);
  - a helper for the width of the first_pat slices.
- Sub-module fault_golden_ram: 2^N_IN x N_OUT, synchronous write, asynchronous read.
- Top level holds the FSM, the settle counter, the pattern and fault counters, and the result registers.

## Test plan
Bench CUT for scenarios 1 and 2 (N_IN=3, N_OUT=1, N_FAULT=2, SETTLE=1): f=(a&b)|c; fault0 = a stuck-at-1; fault1 = c stuck-at-0.
1. Scenario 1, DROP_ON_DETECT=0, start pulse:
   - fault_detected=2'b11;
   - first_pat[0]=3'b010 and first_pat[1]=3'b001;
   - det_count=2;
   - done after edge S+24; pat sequence 0..7 repeated three times; fault_en 00, 01, 10.
2. Scenario 2, same CUT with DROP_ON_DETECT=1:
   - results identical to scenario 1;
   - done after edge S+13 (8+3+2 samples).
3. Redundant fault (the bench CUT ignores that fault_en bit):
   - its fault_detected bit is 0, its first_pat slice is 0;
   - det_count excludes it.
4. SETTLE=3 with a registered-delay CUT model:
   - each pattern is held 3 cycles and results are correct;
   - done after edge S+3*P.
5. Control corner cases:
   - assert start while busy: ignored, with no restart;
   - pull rst_n low mid-FSIM: all outputs are 0 immediately (asynchronously);
   - a fresh start then produces the same results as scenario 1.
6. Back-to-back sweeps:
   - start again the cycle after done;
   - results are cleared at acceptance and then reproduced exactly.
